// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator.
// Decodes the immediate and format of one instruction per cycle and registers
// the result behind a valid/ready handshake backed by a 2-entry skid buffer.
// Optional feature macro: IMM_ILLEGAL_EN adds the out_illegal flag.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Once valid is raised it stays high, and its payload stays stable,
// until the transfer happens. in_ready comes straight from a register
// (~skid_valid) and has no combinational path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_EN
    ,
    output logic             out_illegal
`endif
);

    // Only the two base widths are meaningful; anything else stops elaboration.
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_R     = 3'd1;
    localparam logic [2:0] FMT_I     = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_SHAMT = 3'd7;

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic [TAG_W-1:0] skid_tag;
    logic             accept;
    logic             load_out;

`ifdef IMM_ILLEGAL_EN
    logic dec_ill;
    logic skid_ill;
    logic shift32_wide;
`endif

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign load_out = ~out_valid | out_ready;

    // Decode the immediate from the full 7-bit opcode (inst[1:0] is not assumed).
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        case (in_inst[6:0])
            7'b0010011: begin
                // funct3 001 (slli) and 101 (srli/srai) carry a shift amount.
                if (in_inst[13:12] == 2'b01) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) dec_imm = XLEN'(in_inst[25:20]);
                    else            dec_imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(in_inst[31:20]));
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64; on RV32 it falls to NONE.
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_NONE;
            end
        endcase
    end

`ifdef IMM_ILLEGAL_EN
    // Flag unknown opcodes, non-32-bit encodings and RV32 shifts of 32 or more.
    always_comb begin
        shift32_wide = (XLEN == 32) && (dec_fmt == FMT_SHAMT) && in_inst[25];
        dec_ill      = (dec_fmt == FMT_NONE) || (in_inst[1:0] != 2'b11) || shift32_wide;
    end
`endif

    // Output register plus skid register; flush kills both, data fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= FMT_NONE;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_tag   <= '0;
`ifdef IMM_ILLEGAL_EN
            out_illegal <= 1'b0;
            skid_ill    <= 1'b0;
`endif
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                // Skid is full so in_ready is low: no new input this edge.
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_fmt    <= skid_fmt;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
`ifdef IMM_ILLEGAL_EN
                out_illegal <= skid_ill;
`endif
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= dec_imm;
                out_fmt   <= dec_fmt;
                out_tag   <= in_tag;
`ifdef IMM_ILLEGAL_EN
                out_illegal <= dec_ill;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new entry in the skid register.
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_tag   <= in_tag;
`ifdef IMM_ILLEGAL_EN
            skid_ill   <= dec_ill;
`endif
        end
    end

endmodule
